// File: rtl/id_stage_pipe_pkg.sv
// Purpose: shared opcode constants, enable encodings and opcode-level decode for the ID stage.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package id_stage_pipe_pkg;

  // RV32I base opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic READ_EN   = 1'b1;
  localparam logic READ_DIS  = 1'b0;
  localparam logic WRITE_EN  = 1'b1;
  localparam logic WRITE_DIS = 1'b0;

  typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_IMM_U, OP1_PC} op1_sel_e;
  typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IMM_I, OP2_IMM_U} op2_sel_e;

  typedef struct packed {
    logic     re1;
    logic     re2;
    logic     we;
    logic     is_load;
    op1_sel_e op1_sel;
    op2_sel_e op2_sel;
  } dec_ctrl_t;

  // Opcode-only part of decode: which sources are read, whether rd is written,
  // and where each operand comes from. Unknown opcodes fall out as a NOP.
  function automatic dec_ctrl_t decode_opcode(input logic [6:0] opc);
    dec_ctrl_t c;
    c = '{re1: READ_DIS, re2: READ_DIS, we: WRITE_DIS, is_load: 1'b0,
          op1_sel: OP1_ZERO, op2_sel: OP2_ZERO};
    case (opc)
      OPC_OP_IMM: begin
        c.re1 = READ_EN; c.we = WRITE_EN;
        c.op1_sel = OP1_RS1; c.op2_sel = OP2_IMM_I;
      end
      OPC_OP: begin
        c.re1 = READ_EN; c.re2 = READ_EN; c.we = WRITE_EN;
        c.op1_sel = OP1_RS1; c.op2_sel = OP2_RS2;
      end
      OPC_LUI: begin
        c.we = WRITE_EN; c.op1_sel = OP1_IMM_U;
      end
      OPC_AUIPC: begin
        c.we = WRITE_EN; c.op1_sel = OP1_PC; c.op2_sel = OP2_IMM_U;
      end
      OPC_LOAD: begin
        c.re1 = READ_EN; c.we = WRITE_EN; c.is_load = 1'b1; c.op1_sel = OP1_RS1;
      end
      OPC_JALR: begin
        c.re1 = READ_EN; c.we = WRITE_EN; c.op1_sel = OP1_RS1;
      end
      OPC_STORE, OPC_BRANCH: begin
        c.re1 = READ_EN; c.re2 = READ_EN;
        c.op1_sel = OP1_RS1; c.op2_sel = OP2_RS2;
      end
      OPC_JAL: begin
        c.we = WRITE_EN;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_pipe_load_scoreboard.sv
// Purpose: per-register countdown of cycles until an in-flight load result reaches a forwarding source.
// Latency: set visible on the lookup ports the cycle after set_i; counters drop by one per cycle.
// Backpressure: none; pure state, lookups are combinational.
module load_scoreboard #(
  parameter int RADDR_WIDTH  = 5,
  parameter int LOAD_LATENCY = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   set_i,
  input  logic [RADDR_WIDTH-1:0] set_addr_i,
  input  logic [RADDR_WIDTH-1:0] lkp1_addr_i,
  input  logic [RADDR_WIDTH-1:0] lkp2_addr_i,
  output logic                   lkp1_busy_o,
  output logic                   lkp2_busy_o
);

  localparam int              NREG    = 1 << RADDR_WIDTH;
  localparam int              CNT_W   = 3;
  localparam logic [CNT_W-1:0] SET_VAL = CNT_W'(LOAD_LATENCY - 1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];

  // Count every pending entry down; a new set on the same entry overrides the decrement.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
    end
    if (set_i && (set_addr_i != '0)) begin
      cnt_d[set_addr_i] = SET_VAL;
    end
  end

  // Counter array register.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst_i) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d[i];
    end
  end

  assign lkp1_busy_o = (cnt_q[lkp1_addr_i] != '0);
  assign lkp2_busy_o = (cnt_q[lkp2_addr_i] != '0);

endmodule

// File: rtl/id_stage_pipe.sv
// Purpose: RV32I decode with N-source operand forwarding, load-use stall and a registered ID/EX stage.
// Latency: 1 cycle from accept to out_valid_o.
// Backpressure: in_ready_o drops on stall, flush, reset or a held ID/EX entry; out_* hold while !out_ready_i.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int RADDR_WIDTH  = 5,
  parameter int NUM_FWD      = 2,
  parameter int LOAD_LATENCY = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [31:0]                    inst_i,
  input  logic [ADDR_WIDTH-1:0]          inst_addr_i,
  output logic [RADDR_WIDTH-1:0]         reg1_raddr_o,
  output logic [RADDR_WIDTH-1:0]         reg2_raddr_o,
  output logic                           reg1_re_o,
  output logic                           reg2_re_o,
  input  logic [XLEN-1:0]                reg1_rdata_i,
  input  logic [XLEN-1:0]                reg2_rdata_i,
  input  logic [NUM_FWD-1:0]             fwd_we_i,
  input  logic [NUM_FWD*RADDR_WIDTH-1:0] fwd_waddr_i,
  input  logic [NUM_FWD*XLEN-1:0]        fwd_wdata_i,
  input  logic                           flush_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [31:0]                    out_inst_o,
  output logic [ADDR_WIDTH-1:0]          out_inst_addr_o,
  output logic [XLEN-1:0]                out_op1_o,
  output logic [XLEN-1:0]                out_op2_o,
  output logic                           out_reg_we_o,
  output logic [RADDR_WIDTH-1:0]         out_reg_waddr_o,
  output logic                           out_is_load_o
);

  dec_ctrl_t              ctrl;
  logic [RADDR_WIDTH-1:0] rs1, rs2, rd, raddr1, raddr2;
  logic [XLEN-1:0]        imm_i, imm_u, src1, src2, op1, op2;
  logic                   sb_busy1, sb_busy2, hz1, hz2, stall_ld;
  logic                   accept, handoff;

  logic                   out_valid_q, out_valid_d;
  logic [31:0]            out_inst_q, out_inst_d;
  logic [ADDR_WIDTH-1:0]  out_pc_q, out_pc_d;
  logic [XLEN-1:0]        out_op1_q, out_op1_d, out_op2_q, out_op2_d;
  logic                   out_we_q, out_we_d, out_ld_q, out_ld_d;
  logic [RADDR_WIDTH-1:0] out_wa_q, out_wa_d;

  assign ctrl   = decode_opcode(inst_i[6:0]);
  assign rs1    = RADDR_WIDTH'(inst_i[19:15]);
  assign rs2    = RADDR_WIDTH'(inst_i[24:20]);
  assign rd     = RADDR_WIDTH'(inst_i[11:7]);
  assign raddr1 = ctrl.re1 ? rs1 : '0;
  assign raddr2 = ctrl.re2 ? rs2 : '0;
  assign imm_i  = XLEN'($signed(inst_i[31:20]));
  assign imm_u  = XLEN'($signed({inst_i[31:12], 12'b0}));

  assign reg1_raddr_o = raddr1;
  assign reg2_raddr_o = raddr2;
  assign reg1_re_o    = ctrl.re1;
  assign reg2_re_o    = ctrl.re2;

  // Operand source select: youngest matching forwarding source wins, x0 is hard zero.
  // An unused operand has raddr 0, so it also resolves to zero here.
  always_comb begin
    src1 = reg1_rdata_i;
    src2 = reg2_rdata_i;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_we_i[k] && (fwd_waddr_i[k*RADDR_WIDTH +: RADDR_WIDTH] == raddr1))
        src1 = fwd_wdata_i[k*XLEN +: XLEN];
      if (fwd_we_i[k] && (fwd_waddr_i[k*RADDR_WIDTH +: RADDR_WIDTH] == raddr2))
        src2 = fwd_wdata_i[k*XLEN +: XLEN];
    end
    if (raddr1 == '0) src1 = '0;
    if (raddr2 == '0) src2 = '0;
  end

  // Operand assembly from the per-opcode source selects.
  always_comb begin
    op1 = '0;
    op2 = '0;
    case (ctrl.op1_sel)
      OP1_RS1:   op1 = src1;
      OP1_IMM_U: op1 = imm_u;
      OP1_PC:    op1 = XLEN'(inst_addr_i);
      default:   op1 = '0;
    endcase
    case (ctrl.op2_sel)
      OP2_RS2:   op2 = src2;
      OP2_IMM_I: op2 = imm_i;
      OP2_IMM_U: op2 = imm_u;
      default:   op2 = '0;
    endcase
  end

  // A load sitting in ID/EX has not produced data yet; after handoff the
  // scoreboard covers the remaining cycles until a forwarding source has it.
  assign hz1 = (raddr1 != '0) &&
               (sb_busy1 || (out_valid_q && out_ld_q && (out_wa_q == raddr1)));
  assign hz2 = (raddr2 != '0) &&
               (sb_busy2 || (out_valid_q && out_ld_q && (out_wa_q == raddr2)));
  assign stall_ld = hz1 || hz2;

  assign in_ready_o = !rst_i && !flush_i && !stall_ld && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign handoff    = out_valid_q && out_ready_i && !flush_i;

  load_scoreboard #(
    .RADDR_WIDTH  (RADDR_WIDTH),
    .LOAD_LATENCY (LOAD_LATENCY)
  ) u_sb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .set_i       (handoff && out_ld_q),
    .set_addr_i  (out_wa_q),
    .lkp1_addr_i (raddr1),
    .lkp2_addr_i (raddr2),
    .lkp1_busy_o (sb_busy1),
    .lkp2_busy_o (sb_busy2)
  );

  // ID/EX next state: flush kills, accept loads, handoff without accept bubbles, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    out_we_d    = out_we_q;
    out_wa_d    = out_wa_q;
    out_ld_d    = out_ld_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_inst_d  = inst_i;
      out_pc_d    = inst_addr_i;
      out_op1_d   = op1;
      out_op2_d   = op2;
      out_we_d    = ctrl.we;
      out_wa_d    = ctrl.we ? rd : '0;
      out_ld_d    = ctrl.is_load;
    end else if (handoff) begin
      out_valid_d = 1'b0;
    end
  end

  // ID/EX register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= NOP_INST;
      out_pc_q    <= '0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_we_q    <= 1'b0;
      out_wa_q    <= '0;
      out_ld_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      out_we_q    <= out_we_d;
      out_wa_q    <= out_wa_d;
      out_ld_q    <= out_ld_d;
    end
  end

  assign out_valid_o     = out_valid_q;
  assign out_inst_o      = out_inst_q;
  assign out_inst_addr_o = out_pc_q;
  assign out_op1_o       = out_op1_q;
  assign out_op2_o       = out_op2_q;
  assign out_reg_we_o    = out_we_q;
  assign out_reg_waddr_o = out_wa_q;
  assign out_is_load_o   = out_ld_q;

endmodule
